// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART transmit channel.
package uart_pkg;

  localparam int DV_W_DEF      = 11;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} tx_state_e;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Host byte handshake into the UART transmit sequencer.
interface uart_tx_sequencer_if import uart_pkg::*; #(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_shift_reg.sv
// Data shifter for the TX frame: loads a byte on accept, shifts right on each data-bit tick.
module uart_tx_shift_reg import uart_pkg::*; #(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] din,
  output logic                 lsb
);

  logic [DATA_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (load)
      sr <= din;
    else if (shift)
      sr <= {1'b0, sr[DATA_BITS-1:1]};
  end

  assign lsb = sr[0];

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART TX frame sequencer: owns the baud divisor and serialises bytes on txd per baud tick.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_tx_sequencer import uart_pkg::*; #(
  parameter int              DATA_BITS = DATA_BITS_DEF,
  parameter int              STOP_BITS = 1,
  parameter int              DV_W      = DV_W_DEF,
  parameter logic [DV_W-1:0] DV_RESET  = DV_W'(16)
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_sequencer_if.slave  host,
  input  logic                baud_tick,
  input  logic [DV_W-1:0]     cfg_dv_wdata,
  input  logic                cfg_dv_we,
  input  logic                cfg_parity_odd,
  output logic [DV_W-1:0]     dv,
  output logic                txd,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int BCW = $clog2(DATA_BITS);

  tx_state_e       state, state_nxt;
  logic [BCW-1:0]  bit_cnt, bit_cnt_nxt;
  logic            stop_cnt, stop_cnt_nxt;
  logic            txd_nxt, done_nxt, err_nxt;
  logic [DV_W-1:0] dv_nxt;
  logic            accept, shift, lsb;

  assign host.tx_ready = (state == IDLE) && !rst;
  assign accept        = host.tx_valid && host.tx_ready;
  assign busy          = (state != IDLE);

  uart_tx_shift_reg #(.DATA_BITS(DATA_BITS)) u_shift (
    .clk   (clk),
    .load  (accept),
    .shift (shift),
    .din   (host.tx_data),
    .lsb   (lsb)
  );

`ifdef UART_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (accept)
      par_bit <= (^host.tx_data) ^ cfg_parity_odd;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = cfg_parity_odd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      dv       <= DV_RESET;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      txd      <= txd_nxt;
      done     <= done_nxt;
      cfg_err  <= err_nxt;
      dv       <= dv_nxt;
    end
  end

  // txd is registered: each tick selects the level of the bit that starts after the edge
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    txd_nxt      = txd;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    dv_nxt       = dv;
    shift        = 1'b0;

    if (cfg_dv_we) begin
      if ((state == IDLE) && (cfg_dv_wdata != '0))
        dv_nxt = cfg_dv_wdata;
      else
        err_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (accept)
          state_nxt = SYNC;
      end
      SYNC: if (baud_tick) begin
        state_nxt = START;
        txd_nxt   = 1'b0;
      end
      START: if (baud_tick) begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        txd_nxt     = lsb;
        shift       = 1'b1;
      end
      DATA: if (baud_tick) begin
        if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          state_nxt    = PARITY;
          txd_nxt      = par_bit;
`else
          state_nxt    = STOP;
          txd_nxt      = 1'b1;
          stop_cnt_nxt = 1'b0;
`endif
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          txd_nxt     = lsb;
          shift       = 1'b1;
        end
      end
      PARITY: if (baud_tick) begin
        state_nxt    = STOP;
        txd_nxt      = 1'b1;
        stop_cnt_nxt = 1'b0;
      end
      STOP: if (baud_tick) begin
        if (stop_cnt == 1'(STOP_BITS - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          stop_cnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Randomised self-checking bench for uart_tx_sequencer against a queue-based line model.
module tb_uart_tx_sequencer;
  import uart_pkg::*;

  localparam int              DB  = 8;
  localparam int              SB  = 1;
  localparam int              DVW = 11;
  localparam logic [DVW-1:0]  DVR = 11'd16;
`ifdef UART_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int NF = 1 + DB + NPAR + SB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           baud_tick = 1'b0;
  logic           cfg_dv_we = 1'b0;
  logic           cfg_parity_odd = 1'b0;
  logic [DVW-1:0] cfg_dv_wdata = '0;
  logic [DVW-1:0] dv;
  logic           txd, busy, done, cfg_err;

  uart_tx_sequencer_if #(.DATA_BITS(DB)) host ();

  uart_tx_sequencer #(.DATA_BITS(DB), .STOP_BITS(SB), .DV_W(DVW), .DV_RESET(DVR)) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (host.slave),
    .baud_tick      (baud_tick),
    .cfg_dv_wdata   (cfg_dv_wdata),
    .cfg_dv_we      (cfg_dv_we),
    .cfg_parity_odd (cfg_parity_odd),
    .dv             (dv),
    .txd            (txd),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Baud tick: one-cycle pulse every 4 clocks
  int tcnt = 0;
  always @(negedge clk) begin
    tcnt      = (tcnt + 1) % 4;
    baud_tick = (tcnt == 0);
  end

  // Reference model: a frame is a queue of line levels, one popped per tick
  bit             m_q[$];
  bit             m_active = 1'b0;
  bit             m_line   = 1'b1;
  bit             m_done   = 1'b0;
  bit             m_err    = 1'b0;
  logic [DVW-1:0] m_dv     = DVR;
  int             acc_cnt  = 0;
  int             dut_done_cnt = 0;

  function automatic void push_frame(input logic [DB-1:0] d, input logic odd);
    m_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) m_q.push_back(d[i]);
`ifdef UART_PARITY_EN
    m_q.push_back((^d) ^ odd);
`endif
    for (int i = 0; i < SB; i++) m_q.push_back(1'b1);
  endfunction

  always @(posedge clk) begin
    bit was_active;
    was_active = m_active;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_line   = 1'b1;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_dv     = DVR;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (was_active && baud_tick) begin
        if (m_q.size() > 0) begin
          m_line = m_q.pop_front();
        end else begin
          m_line   = 1'b1;
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      if (!was_active && host.tx_valid) begin
        push_frame(host.tx_data, cfg_parity_odd);
        m_active = 1'b1;
        acc_cnt++;
      end
      if (cfg_dv_we) begin
        if (!was_active && cfg_dv_wdata != '0) m_dv = cfg_dv_wdata;
        else m_err = 1'b1;
      end
    end
    #1;
    if (done) dut_done_cnt++;
    check("txd",      txd,           m_line);
    check("busy",     busy,          m_active);
    check("done",     done,          m_done);
    check("cfg_err",  cfg_err,       m_err);
    check("dv",       dv,            m_dv);
    check("tx_ready", host.tx_ready, !m_active && !rst);
  end

  task automatic send(input logic [DB-1:0] d, input logic odd);
    int start;
    start = acc_cnt;
    @(negedge clk);
    host.tx_valid  = 1'b1;
    host.tx_data   = d;
    cfg_parity_odd = odd;
    for (int i = 0; i < 200 && acc_cnt == start; i++) @(negedge clk);
    check("accept_timeout", acc_cnt != start, 1);
    host.tx_valid = 1'b0;
    host.tx_data  = DB'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy || m_active); i++) @(negedge clk);
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int d0;
    int start;
    host.tx_valid = 1'b0;
    host.tx_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // even then odd parity on 0xA5, one done per frame
    d0 = dut_done_cnt;
    send(8'hA5, 1'b0);
    wait_idle();
    check("done_once_even", dut_done_cnt - d0, 1);
    d0 = dut_done_cnt;
    send(8'hA5, 1'b1);
    wait_idle();
    check("done_once_odd", dut_done_cnt - d0, 1);

    // back-to-back frames with tx_valid held
    @(negedge clk);
    start         = acc_cnt;
    host.tx_valid = 1'b1;
    host.tx_data  = 8'h00;
    for (int i = 0; i < 200 && acc_cnt == start; i++) @(negedge clk);
    host.tx_data = 8'hFF;
    for (int i = 0; i < 400 && acc_cnt < start + 2; i++) @(negedge clk);
    check("b2b_accepts", acc_cnt - start, 2);
    host.tx_valid = 1'b0;
    wait_idle();

    // divisor writes: idle ok, busy rejected, zero rejected
    @(negedge clk);
    cfg_dv_we    = 1'b1;
    cfg_dv_wdata = 11'd100;
    @(negedge clk);
    cfg_dv_we = 1'b0;
    check("dv_idle_write", dv, 100);
    send(8'h3C, 1'b0);
    cfg_dv_we    = 1'b1;
    cfg_dv_wdata = 11'd77;
    @(negedge clk);
    cfg_dv_we = 1'b0;
    check("dv_busy_write", dv, 100);
    check("err_busy_write", cfg_err, 1);
    wait_idle();
    @(negedge clk);
    cfg_dv_we    = 1'b1;
    cfg_dv_wdata = '0;
    @(negedge clk);
    cfg_dv_we = 1'b0;
    check("dv_zero_write", dv, 100);
    check("err_zero_write", cfg_err, 1);

    // reset during data bit 3
    d0 = dut_done_cnt;
    send(8'h5A, 1'b0);
    for (int i = 0; i < 200 && m_q.size() != NF - 5; i++) @(negedge clk);
    check("reached_bit3", m_q.size(), NF - 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_txd",   txd, 1);
    check("rst_busy",  busy, 0);
    check("rst_ready", host.tx_ready, 1);
    check("rst_dv",    dv, DVR);
    check("rst_nodone", dut_done_cnt - d0, 0);

    // accept in the same cycle as a baud tick
    @(negedge clk);
    #1;
    for (int i = 0; i < 8 && !baud_tick; i++) begin
      @(negedge clk);
      #1;
    end
    check("tick_aligned", baud_tick, 1);
    host.tx_valid = 1'b1;
    host.tx_data  = 8'hC3;
    @(negedge clk);
    host.tx_valid = 1'b0;
    wait_idle();

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      host.tx_valid  = ($urandom_range(0, 3) == 0);
      host.tx_data   = DB'($urandom);
      cfg_parity_odd = 1'($urandom);
      cfg_dv_we      = ($urandom_range(0, 15) == 0);
      cfg_dv_wdata   = ($urandom_range(0, 3) == 0) ? '0 : DVW'($urandom);
      rst            = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    host.tx_valid = 1'b0;
    cfg_dv_we     = 1'b0;
    rst           = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
